// File: rtl/i2s_pkg.sv
// Shared types for the I2S receiver: sample/stereo words and the
// deserializer state encoding.
package i2s_pkg;

    localparam int DATA_W = 24;

    typedef logic signed [DATA_W-1:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } rx_state_e;

endpackage

// File: rtl/i2s_rx_fifo.sv
// Synchronous FIFO of stereo pairs with registered head.
// Ports: push/push_data write side, pop read side, head = oldest entry,
// full/empty flags and level = occupancy (0..DEPTH).
module i2s_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push,
    input  i2s_pkg::stereo_t         push_data,
    input  logic                     pop,
    output i2s_pkg::stereo_t         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    import i2s_pkg::*;

    localparam int AW = $clog2(DEPTH);

    stereo_t     mem_q [DEPTH];
    stereo_t     mem_d [DEPTH];
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic        do_push;
    logic        do_pop;

    // Extra pointer MSB distinguishes full from empty.
    assign level = wr_q - rd_q;
    assign empty = (wr_q == rd_q);
    assign full  = (level == (AW+1)'(DEPTH));
    assign head  = mem_q[rd_q[AW-1:0]];

    // A pop frees the slot in the same cycle, so a full FIFO still
    // accepts a push when it is popped at the same time.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = push_data;
            wr_d = wr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples SCLK/LRCLK/Din, deserializes L/R words and
// queues complete stereo pairs behind a valid/ready pop interface.
// Ports: CLK/RESET system side; SCLK, LRCLK, Din from the codec; enable;
// sample_valid/ready/left/right handshake; fifo_level; sticky overflow
// with overflow_clear.
module i2s_rx #(
    parameter int DATA_W      = i2s_pkg::DATA_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          SCLK,
    input  logic                          LRCLK,
    input  logic                          Din,
    input  logic                          enable,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [DATA_W-1:0]             sample_left,
    output logic [DATA_W-1:0]             sample_right,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          overflow_clear
);
    import i2s_pkg::*;

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] lr_sync_q, lr_sync_d;
    logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;

    rx_state_e              state_q, state_d;
    logic                   lr_prev_q, lr_prev_d;
    logic                   chan_q, chan_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]      sr_q, sr_d;
    logic [DATA_W-1:0]      left_hold_q, left_hold_d;
    logic                   have_left_q, have_left_d;
    logic                   push_q, push_d;
    stereo_t                push_data_q, push_data_d;
    logic                   overflow_q, overflow_d;

    logic    sclk_s, lr_s, din_s;
    logic    rise, boundary, shift_en, word_done;
    logic    fifo_full, fifo_empty, pop, drop;
    stereo_t fifo_head;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign lr_s   = lr_sync_q[SYNC_STAGES-1];
    assign din_s  = din_sync_q[SYNC_STAGES-1];

    assign rise     = sclk_s & ~sclk_prev_q;
    // The bit on a boundary rise is the previous slot's LSB: never shifted.
    assign boundary = rise & (lr_s ^ lr_prev_q);
    assign shift_en = rise & ~boundary & enable & (state_q == SHIFT);
    assign word_done = shift_en & (cnt_q == CNT_W'(DATA_W - 1));

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (boundary) state_d = SHIFT;
            end
            SHIFT: begin
                if (boundary) state_d = SHIFT;
                else if (word_done) state_d = HOLD;
            end
            HOLD: begin
                if (boundary) state_d = SHIFT;
            end
            default: state_d = IDLE;
        endcase
        if (!enable) state_d = IDLE;
    end

    // Datapath / output logic
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
        lr_sync_d   = {lr_sync_q[SYNC_STAGES-2:0], LRCLK};
        din_sync_d  = {din_sync_q[SYNC_STAGES-2:0], Din};
        sclk_prev_d = sclk_s;

        // lr_prev tracks LRCLK even while disabled so that re-enabling
        // waits for a genuine slot edge.
        lr_prev_d   = boundary ? lr_s : lr_prev_q;
        chan_d      = boundary ? lr_s : chan_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        left_hold_d = left_hold_q;
        have_left_d = have_left_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;

        if (boundary) begin
            cnt_d = '0;
            // Slot ended before a full word: the frame is broken.
            if (state_q == SHIFT) have_left_d = 1'b0;
        end else if (shift_en) begin
            sr_d  = {sr_q[DATA_W-2:0], din_s};
            cnt_d = cnt_q + CNT_W'(1);
            if (word_done) begin
                if (!chan_q) begin
                    left_hold_d = sr_d;
                    have_left_d = 1'b1;
                end else if (have_left_q) begin
                    push_d        = 1'b1;
                    push_data_d.l = left_hold_q;
                    push_data_d.r = sr_d;
                    have_left_d   = 1'b0;
                end
            end
        end

        if (!enable) begin
            cnt_d       = '0;
            have_left_d = 1'b0;
        end

        // A drop in the same cycle as a clear keeps the flag set.
        overflow_d = drop | (overflow_q & ~overflow_clear);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sclk_sync_q <= '0;
            lr_sync_q   <= '0;
            din_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            lr_prev_q   <= 1'b0;
            chan_q      <= 1'b0;
            cnt_q       <= '0;
            sr_q        <= '0;
            left_hold_q <= '0;
            have_left_q <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            lr_sync_q   <= lr_sync_d;
            din_sync_q  <= din_sync_d;
            sclk_prev_q <= sclk_prev_d;
            lr_prev_q   <= lr_prev_d;
            chan_q      <= chan_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            left_hold_q <= left_hold_d;
            have_left_q <= have_left_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            overflow_q  <= overflow_d;
        end
    end

    assign pop  = ~fifo_empty & sample_ready;
    assign drop = push_q & fifo_full & ~pop;

    i2s_rx_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (push_q),
        .push_data (push_data_q),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign sample_valid = ~fifo_empty;
    assign sample_left  = fifo_head.l;
    assign sample_right = fifo_head.r;
    assign overflow     = overflow_q;

endmodule
